// File: rtl/alu_issue_r0_pkg.sv
// rtl/alu_issue_r0_pkg.sv - shared R-type opcode/funct codes, status bit indices and FSM encodings
package alu_issue_r0_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  localparam int STATUS_OVF_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_addsub(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - combinational R-type decode: legality, shift class, ALU ctrl and shamt
module alu_funct_decode
  import alu_issue_r0_pkg::*;
#(
  parameter int CTRL_WIDTH  = 6,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [31:0]            instr,
  output logic                   legal,
  output logic                   is_shift,
  output logic [CTRL_WIDTH-1:0]  ctrl,
  output logic [SHAMT_WIDTH-1:0] shamt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_rs_rt_rd;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign unused_rs_rt_rd = ^instr[25:11];

  always_comb begin
    legal    = 1'b0;
    is_shift = 1'b0;
    if (opcode == OPCODE_RTYPE) begin
      case (funct)
        FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
          legal    = 1'b1;
          is_shift = 1'b1;
        end
        FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  assign ctrl  = CTRL_WIDTH'(funct);
  assign shamt = is_shift ? SHAMT_WIDTH'(instr[10:6]) : '0;

endmodule

// File: rtl/alu_issue_r0.sv
// rtl/alu_issue_r0.sv - R-type ALU issue/response sequencer; ALU_ISSUE_OVF_TRAP_EN turns add/sub overflow into out_err
module alu_issue_r0
  import alu_issue_r0_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CTRL_WIDTH   = 6,
  parameter int STATUS_WIDTH = 4,
  parameter int SHAMT_WIDTH  = 5,
  parameter int ALU_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [DATA_WIDTH-1:0]   in_opA,
  input  logic [DATA_WIDTH-1:0]   in_opB,
  output logic [2*DATA_WIDTH-1:0] alu_dataIn,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl,
  output logic [SHAMT_WIDTH-1:0]  alu_shamt,
  input  logic [DATA_WIDTH-1:0]   alu_dataOut,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [4:0]              out_rd,
  output logic [STATUS_WIDTH-1:0] out_status,
  output logic                    out_err
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   started;
  logic                   illegal_q;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   dec_legal;
  logic                   dec_shift;
  logic [CTRL_WIDTH-1:0]  dec_ctrl;
  logic [SHAMT_WIDTH-1:0] dec_shamt;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic                   addsub_q;
`endif

  alu_funct_decode #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_decode (
    .instr   (in_instr),
    .legal   (dec_legal),
    .is_shift(dec_shift),
    .ctrl    (dec_ctrl),
    .shamt   (dec_shamt)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)       state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == '0)    state_nxt = ST_RESP;
      ST_RESP: if (out_ready)    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // in_ready stays low through reset and only rises on the first edge after release
  always_comb begin
    in_ready  = (state == ST_IDLE) && started;
    out_valid = (state == ST_RESP);
  end

  // Illegal instructions take one EXEC cycle with the ALU untouched, so out_valid lands at N+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started    <= 1'b0;
      illegal_q  <= 1'b0;
      cnt        <= '0;
      alu_dataIn <= '0;
      alu_ctrl   <= '0;
      alu_shamt  <= '0;
      out_result <= '0;
      out_rd     <= '0;
      out_status <= '0;
      out_err    <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
      addsub_q   <= 1'b0;
`endif
    end else begin
      started <= 1'b1;
      if (accept) begin
        out_rd    <= in_instr[15:11];
        illegal_q <= !dec_legal;
        cnt       <= dec_legal ? CNT_W'(ALU_LATENCY - 1) : '0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        addsub_q  <= is_addsub(in_instr[5:0]);
`endif
        if (dec_legal) begin
          alu_ctrl   <= dec_ctrl;
          alu_shamt  <= dec_shamt;
          alu_dataIn <= dec_shift ? {{DATA_WIDTH{1'b0}}, in_opB} : {in_opB, in_opA};
        end
      end else if (state == ST_EXEC) begin
        if (cnt == '0) begin
          if (illegal_q) begin
            out_result <= '0;
            out_status <= '0;
            out_err    <= 1'b1;
          end else begin
            out_result <= alu_dataOut;
            out_status <= alu_status;
            out_err    <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
            if (addsub_q && alu_status[STATUS_OVF_BIT]) begin
              out_result <= '0;
              out_err    <= 1'b1;
            end
`endif
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_r0.sv
// tb/tb_alu_issue_r0.sv - directed self-checking bench for alu_issue_r0 with a combinational ALU model
module tb_alu_issue_r0;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_opA;
  logic [7:0]  in_opB;
  logic [15:0] alu_dataIn;
  logic [5:0]  alu_ctrl;
  logic [4:0]  alu_shamt;
  logic [7:0]  alu_dataOut;
  logic [3:0]  alu_status;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_result;
  logic [4:0]  out_rd;
  logic [3:0]  out_status;
  logic        out_err;

  int compared   = 0;
  int mismatched = 0;

  alu_issue_r0 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_opA     (in_opA),
    .in_opB     (in_opB),
    .alu_dataIn (alu_dataIn),
    .alu_ctrl   (alu_ctrl),
    .alu_shamt  (alu_shamt),
    .alu_dataOut(alu_dataOut),
    .alu_status (alu_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_status (out_status),
    .out_err    (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model, latency 1: result valid combinationally from the registered inputs
  logic [7:0] a, b, r;
  logic       ovf;
  always_comb begin
    a   = alu_dataIn[7:0];
    b   = alu_dataIn[15:8];
    r   = 8'h00;
    ovf = 1'b0;
    case (alu_ctrl)
      6'h00: r = a << alu_shamt;
      6'h02: r = a >> alu_shamt;
      6'h03: r = $signed(a) >>> alu_shamt;
      6'h20: begin r = a + b; ovf = (a[7] == b[7]) && (r[7] != a[7]); end
      6'h22: begin r = a - b; ovf = (a[7] != b[7]) && (r[7] != a[7]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      default: r = 8'h00;
    endcase
    alu_dataOut = r;
    alu_status  = {ovf, 1'b0, r[7], (r == 8'h00)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, 10'd0, rd, sh, fn};
  endfunction

  task automatic send(input string tag, input logic [31:0] instr, input logic [7:0] opa, input logic [7:0] opb);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_instr = instr;
    in_opA   = opa;
    in_opB   = opb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic complete(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic check_resp(input string tag, input logic [7:0] res, input logic [4:0] rd,
                            input logic [3:0] st, input logic err);
    check({tag, "_result"}, out_result, res);
    check({tag, "_rd"}, out_rd, rd);
    check({tag, "_status"}, out_status, st);
    check({tag, "_err"}, out_err, err);
  endtask

  initial begin
    bit seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_opA    = '0;
    in_opB    = '0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dataIn", alu_dataIn, 0);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_err", out_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", in_ready, 1);

    // add
    send("add", rtype(6'h00, 5'd3, 5'd0, 6'h20), 8'h12, 8'h34);
    check("add_dataIn", alu_dataIn, 16'h3412);
    check("add_ctrl", alu_ctrl, 6'h20);
    check("add_shamt", alu_shamt, 0);
    check("add_no_valid_at_N", out_valid, 0);
    wait_valid("add", 1);
    check_resp("add", 8'h46, 5'd3, 4'h0, 1'b0);
    complete("add");

    // illegal opcode: ALU inputs untouched
    send("ill_op", rtype(6'h08, 5'd9, 5'd0, 6'h20), 8'h55, 8'h66);
    check("ill_op_ctrl", alu_ctrl, 6'h20);
    check("ill_op_dataIn", alu_dataIn, 16'h3412);
    check("ill_op_no_valid_at_N", out_valid, 0);
    wait_valid("ill_op", 1);
    check_resp("ill_op", 8'h00, 5'd9, 4'h0, 1'b1);
    complete("ill_op");

    // sll
    send("sll", rtype(6'h00, 5'd5, 5'd3, 6'h00), 8'hAA, 8'h11);
    check("sll_dataIn", alu_dataIn, 16'h0011);
    check("sll_shamt", alu_shamt, 3);
    wait_valid("sll", 1);
    check_resp("sll", 8'h88, 5'd5, 4'h2, 1'b0);
    complete("sll");

    // illegal funct
    send("ill_fn", rtype(6'h00, 5'd10, 5'd7, 6'h18), 8'h01, 8'h02);
    check("ill_fn_ctrl", alu_ctrl, 6'h00);
    check("ill_fn_shamt", alu_shamt, 3);
    wait_valid("ill_fn", 1);
    check_resp("ill_fn", 8'h00, 5'd10, 4'h0, 1'b1);
    complete("ill_fn");

    // sra
    send("sra", rtype(6'h00, 5'd4, 5'd2, 6'h03), 8'h00, 8'h80);
    check("sra_dataIn", alu_dataIn, 16'h0080);
    wait_valid("sra", 1);
    check_resp("sra", 8'hE0, 5'd4, 4'h2, 1'b0);
    complete("sra");

    // nor to zero, rd at its top value
    send("nor", rtype(6'h00, 5'd31, 5'd0, 6'h27), 8'h0F, 8'hF0);
    check("nor_shamt", alu_shamt, 0);
    wait_valid("nor", 1);
    check_resp("nor", 8'h00, 5'd31, 4'h1, 1'b0);
    complete("nor");

    // backpressure with a competing in_valid that must be ignored
    send("or", rtype(6'h00, 5'd6, 5'd0, 6'h25), 8'h0C, 8'h30);
    wait_valid("or", 1);
    in_valid = 1'b1;
    in_instr = rtype(6'h00, 5'd1, 5'd0, 6'h26);
    in_opA   = 8'hFF;
    in_opB   = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 8'h3C);
      check("bp_in_ready", in_ready, 0);
      check("bp_ctrl_held", alu_ctrl, 6'h25);
    end
    in_valid = 1'b0;
    check_resp("or", 8'h3C, 5'd6, 4'h0, 1'b0);
    complete("or");

    // signed overflow on sub
    send("ovf", rtype(6'h00, 5'd2, 5'd0, 6'h22), 8'h80, 8'h01);
    wait_valid("ovf", 1);
`ifdef ALU_ISSUE_OVF_TRAP_EN
    check_resp("ovf", 8'h00, 5'd2, 4'h8, 1'b1);
`else
    check_resp("ovf", 8'h7F, 5'd2, 4'h8, 1'b0);
`endif
    complete("ovf");

    // reset in the middle of EXEC
    send("mid", rtype(6'h00, 5'd12, 5'd0, 6'h24), 8'hF0, 8'h3C);
    rst = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_dataIn", alu_dataIn, 0);
    check("mid_ctrl", alu_ctrl, 0);
    check("mid_result", out_result, 0);
    check("mid_rd", out_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid_no_valid_after", seen_valid, 0);

    send("xor", rtype(6'h00, 5'd7, 5'd0, 6'h26), 8'h0F, 8'hFF);
    check("xor_dataIn", alu_dataIn, 16'hFF0F);
    wait_valid("xor", 1);
    check_resp("xor", 8'hF0, 5'd7, 4'h2, 1'b0);
    complete("xor");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
